// File: rtl/lod_iter_scan_if.sv
// Handshake bundle for lod_iter_scan: operand in, leading-one result out.
// Optional macro LOD_LSB_EN adds the in_lsb scan-direction select.
interface lod_iter_scan_if #(
  parameter int WIDTH = 32
);
  localparam int IDXW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
`ifdef LOD_LSB_EN
  logic             in_lsb;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_index;
  logic             out_found;

  // Producer/consumer side
  modport master (
`ifdef LOD_LSB_EN
    output in_lsb,
`endif
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_index,
    input  out_found,
    output out_ready
  );

  // Detector side
  modport slave (
`ifdef LOD_LSB_EN
    input  in_lsb,
`endif
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_index,
    output out_found,
    input  out_ready
  );
endinterface

// File: rtl/lod_iter_scan.sv
// Multi-cycle leading-one detector. Scans CHUNK bits per cycle from the MSB
// chunk down and stops on the first nonzero chunk. Optional macro LOD_LSB_EN
// adds a per-operand select for a trailing-one scan from chunk 0 upward.
module lod_iter_scan #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  lod_iter_scan_if.slave bus
);
  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = $clog2(WIDTH);
  localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] operand;
  logic [CNTW-1:0]  cnt;
  logic [IDXW-1:0]  index_r;
  logic             found_r;
`ifdef LOD_LSB_EN
  logic             lsb_mode;
`endif
  logic [CNTW-1:0]  chunk_sel;
  logic [CHUNK-1:0] chunk;
  logic [IDXW-1:0]  base;
  logic [IDXW-1:0]  hit_index;
  logic             hit;
  logic             ready_c;
  logic             valid_c;

  // Position of the highest set bit inside one chunk (0 if empty)
  function automatic logic [IDXW-1:0] top_bit(input logic [CHUNK-1:0] v);
    top_bit = '0;
    for (int i = 0; i < CHUNK; i++)
      if (v[i]) top_bit = IDXW'(i);
  endfunction

  // Position of the lowest set bit inside one chunk (0 if empty)
  function automatic logic [IDXW-1:0] bottom_bit(input logic [CHUNK-1:0] v);
    bottom_bit = '0;
    for (int i = CHUNK - 1; i >= 0; i--)
      if (v[i]) bottom_bit = IDXW'(i);
  endfunction

  // Select the chunk under examination and form its candidate index
  always_comb begin
    chunk_sel = LAST - cnt;
`ifdef LOD_LSB_EN
    if (lsb_mode) chunk_sel = cnt;
`endif
    chunk     = operand[int'(chunk_sel) * CHUNK +: CHUNK];
    hit       = |chunk;
    base      = IDXW'(int'(chunk_sel) * CHUNK);
    hit_index = base + top_bit(chunk);
`ifdef LOD_LSB_EN
    if (lsb_mode) hit_index = base + bottom_bit(chunk);
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    valid_c   = 1'b0;
    case (state)
      IDLE: begin
        ready_c = !rst;
        if (bus.in_valid && !rst) state_nxt = SCAN;
      end
      SCAN: begin
        if (hit || cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, chunk counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      operand  <= '0;
      cnt      <= '0;
      index_r  <= '0;
      found_r  <= 1'b0;
`ifdef LOD_LSB_EN
      lsb_mode <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            operand  <= bus.in_data;
            cnt      <= '0;
`ifdef LOD_LSB_EN
            lsb_mode <= bus.in_lsb;
`endif
          end
        end
        SCAN: begin
          if (hit) begin
            index_r <= hit_index;
            found_r <= 1'b1;
          end else if (cnt == LAST) begin
            index_r <= '1;
            found_r <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = valid_c;
  assign bus.out_index = index_r;
  assign bus.out_found = found_r;
endmodule

// File: tb/tb_lod_iter_scan.sv
// Self-checking bench for lod_iter_scan (WIDTH=32, CHUNK=8).
module tb_lod_iter_scan;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDXW  = 5;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lod_iter_scan_if #(.WIDTH(WIDTH)) bus();

  lod_iter_scan #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference: the leading (or trailing) one of the whole word is the answer;
  // scan cycles follow from which chunk it lives in.
  function automatic void model(input logic [WIDTH-1:0] d, input bit lsb,
                                output logic [IDXW-1:0] idx, output bit found,
                                output int j);
    found = 1'b0;
    idx   = '1;
    j     = NCH;
    if (!lsb) begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (d[i] && !found) begin
          found = 1'b1;
          idx   = IDXW'(i);
          j     = NCH - i / CHUNK;
        end
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (d[i] && !found) begin
          found = 1'b1;
          idx   = IDXW'(i);
          j     = i / CHUNK + 1;
        end
    end
  endfunction

  task automatic set_lsb(input bit lsb);
`ifdef LOD_LSB_EN
    bus.in_lsb = lsb;
`else
    if (lsb) $display("note: lsb mode not built");
`endif
  endtask

  task automatic start_op(input logic [WIDTH-1:0] d, input bit lsb, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      set_lsb(lsb);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      set_lsb(1'b0);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.out_valid) break;
      if (n >= 40) begin
        n = -1;
        break;
      end
    end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_index !== 5'd0) begin errors++; $display("FAIL rst_out_index: got %0d expected 0", bus.out_index); end
    checks++; if (bus.out_found !== 1'b0) begin errors++; $display("FAIL rst_out_found: got %b expected 0", bus.out_found); end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] dv [4] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0001_0300};
    int               jv [4] = '{1, 4, 4, 2};
    logic [IDXW-1:0]  iv [4] = '{5'd31, 5'd0, 5'h1F, 5'd16};
    bit               fv [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit ok;
    int n;
    for (int t = 0; t < 4; t++) begin
      start_op(dv[t], 1'b0, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL dir_accept[%0d]: got %b expected 1", t, ok); end
      wait_valid(n);
      checks++; if (n != jv[t]) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", t, n, jv[t]); end
      checks++; if (bus.out_index !== iv[t]) begin errors++; $display("FAIL dir_index[%0d]: got %0d expected %0d", t, bus.out_index, iv[t]); end
      checks++; if (bus.out_found !== fv[t]) begin errors++; $display("FAIL dir_found[%0d]: got %b expected %b", t, bus.out_found, fv[t]); end
      finish_op();
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL dir_ready_after[%0d]: got %b expected 1", t, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dir_valid_after[%0d]: got %b expected 0", t, bus.out_valid); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    start_op(32'h0001_0300, 1'b0, ok);
    wait_valid(n);
    checks++; if (n != 2) begin errors++; $display("FAIL bp_latency: got %0d expected 2", n); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, bus.out_valid); end
      checks++; if (bus.out_index !== 5'd16) begin errors++; $display("FAIL bp_index[%0d]: got %0d expected 16", k, bus.out_index); end
      checks++; if (bus.out_found !== 1'b1) begin errors++; $display("FAIL bp_found[%0d]: got %b expected 1", k, bus.out_found); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, bus.in_ready); end
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    finish_op();
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_after: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    start_op(32'h0000_0001, 1'b0, ok);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_in_rst: got %b expected 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_index !== 5'd0) begin errors++; $display("FAIL mid_index: got %0d expected 0", bus.out_index); end
    checks++; if (bus.out_found !== 1'b0) begin errors++; $display("FAIL mid_found: got %b expected 0", bus.out_found); end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_result: got %b expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d;
    logic [IDXW-1:0]  ei;
    bit               ef;
    int               ej, pj, t, pt, n;
    bit               ok;
    pt = 0;
    pj = 0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      d = $urandom >> $urandom_range(0, 32);
      model(d, 1'b0, ei, ef, ej);
      ok = 1'b0;
      for (int w = 0; w < 30; w++) begin
        @(negedge clk);
        if (bus.in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d]: got %b expected 1", k, ok); end
      t = cyc;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      if (k > 0) begin
        checks++; if (t - pt != pj + 2) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d expected %0d", k, t - pt, pj + 2); end
      end
      pt = t;
      pj = ej;
      @(posedge clk);
      #1;
      bus.in_data = $urandom;
      wait_valid(n);
      checks++; if (n != ej) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", k, n, ej); end
      checks++; if (bus.out_index !== ei) begin errors++; $display("FAIL b2b_index[%0d]: got %0d expected %0d", k, bus.out_index, ei); end
      checks++; if (bus.out_found !== ef) begin errors++; $display("FAIL b2b_found[%0d]: got %b expected %b", k, bus.out_found, ef); end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] d;
    logic [IDXW-1:0]  ei;
    bit               ef, lsb, ok;
    int               ej, n, hold;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 2))
        0:       d = $urandom >> $urandom_range(0, 32);
        1:       d = 32'h1 << $urandom_range(0, 31);
        default: d = $urandom << $urandom_range(0, 31);
      endcase
`ifdef LOD_LSB_EN
      lsb = 1'($urandom_range(0, 1));
`else
      lsb = 1'b0;
`endif
      model(d, lsb, ei, ef, ej);
      start_op(d, lsb, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rnd_accept[%0d]: got %b expected 1", k, ok); end
      wait_valid(n);
      checks++; if (n != ej) begin errors++; $display("FAIL rnd_latency[%0d] d=%h: got %0d expected %0d", k, d, n, ej); end
      hold = $urandom_range(0, 3);
      for (int h = 0; h <= hold; h++) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_index !== ei || bus.out_found !== ef) begin
          errors++;
          $display("FAIL rnd_result[%0d] d=%h: got v=%b i=%0d f=%b expected v=1 i=%0d f=%b", k, d, bus.out_valid, bus.out_index, bus.out_found, ei, ef);
        end
        if (h < hold) begin
          @(posedge clk);
          @(negedge clk);
        end
      end
      finish_op();
    end
  endtask

`ifdef LOD_LSB_EN
  task automatic test_lsb();
    bit ok;
    int n;
    start_op(32'h0001_0300, 1'b1, ok);
    wait_valid(n);
    checks++; if (n != 2) begin errors++; $display("FAIL lsb1_latency: got %0d expected 2", n); end
    checks++; if (bus.out_index !== 5'd8) begin errors++; $display("FAIL lsb1_index: got %0d expected 8", bus.out_index); end
    checks++; if (bus.out_found !== 1'b1) begin errors++; $display("FAIL lsb1_found: got %b expected 1", bus.out_found); end
    finish_op();
    start_op(32'h0001_0300, 1'b0, ok);
    wait_valid(n);
    checks++; if (n != 2) begin errors++; $display("FAIL lsb0_latency: got %0d expected 2", n); end
    checks++; if (bus.out_index !== 5'd16) begin errors++; $display("FAIL lsb0_index: got %0d expected 16", bus.out_index); end
    finish_op();
  endtask
`endif

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    set_lsb(1'b0);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef LOD_LSB_EN
    test_lsb();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
